imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 32, byte address width in bits.
REQ-003 SHALL have parameter BASEADDR, default 32'h01000000, byte address of word 0.
REQ-004 SHALL have parameter DEPTH_WORDS, default 1024, number of storage words.
REQ-005 SHALL have parameter LATENCY, default 2, cycles from request acceptance to rsp_valid_o (legal range 1..15).
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid_i, input, 1, request present.
REQ-009 SHALL have port req_ready_o, output, 1, responder can accept a request.
REQ-010 SHALL have port req_addr_i, input, AWIDTH, byte address.
REQ-011 SHALL have port req_we_i, input, 1, 1 = write, 0 = read.
REQ-012 SHALL have port req_wdata_i, input, DWIDTH, write data.
REQ-013 SHALL have port rsp_valid_o, output, 1, response present.
REQ-014 SHALL have port rsp_ready_i, input, 1, requester accepts the response.
REQ-015 SHALL have port rsp_data_o, output, DWIDTH, read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_err_o, output, 1, access error flag.

Function
REQ-017 SHALL use FSM states IDLE, WAIT, RESP; exactly one outstanding request.
REQ-018 SHALL drive req_ready_o = 1 only in IDLE.
REQ-019 SHALL accept a request on a posedge where req_valid_i && req_ready_o, capturing addr, we, wdata.
REQ-020 SHALL, on acceptance, go to RESP if LATENCY = 1, else go to WAIT with a down-counter loaded to LATENCY-1.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and go to RESP when it reaches 0, so rsp_valid_o rises exactly LATENCY cycles after the acceptance edge.
REQ-022 SHALL, in RESP, hold rsp_valid_o, rsp_data_o and rsp_err_o stable until rsp_ready_i is sampled high, then return to IDLE.
REQ-023 SHALL NOT accept a new request in the same cycle as a response handshake; the earliest next acceptance is one cycle after return to IDLE.
REQ-024 SHALL compute word index = (addr - BASEADDR) >> 2 with AWIDTH-bit unsigned arithmetic.
REQ-025 SHALL flag an error when addr < BASEADDR or addr >= BASEADDR + 4*DEPTH_WORDS (including wrap past 2^AWIDTH); rsp_data_o = 0 and the write is suppressed.
REQ-026 SHALL commit a valid write to storage on the acceptance edge; a read issued afterwards returns the new data.
REQ-027 SHALL return read data sampled at the acceptance edge; rsp_data_o is unaffected by later storage changes.
REQ-028 SHALL ignore req_addr_i, req_we_i and req_wdata_i when no acceptance occurs.

Reset
REQ-029 SHALL, on rst low, immediately force state IDLE, counter 0, rsp_valid_o 0, rsp_data_o 0, rsp_err_o 0, and req_ready_o 1 once rst is high.
REQ-030 SHALL abandon any in-flight request on reset mid-operation without producing a response; storage contents are preserved (not cleared).

Configuration
REQ-031 SHALL, with IMEM_MISALIGN_CHECK_EN defined, flag rsp_err_o for addr[1:0] != 0 and suppress the access.
REQ-032 SHALL, without IMEM_MISALIGN_CHECK_EN, ignore addr[1:0] and access the containing word.

Structure
REQ-033 SHALL place the FSM state enum and the response struct (data, err) in shared package imem_pkg.
REQ-034 SHALL instantiate sub-module imem_array for storage: synchronous write, combinational read, DEPTH_WORDS x DWIDTH.

Verification
REQ-035 SHALL cover: reset, LATENCY=2, read 0x01000000 holding 0xDEADBEEF -> rsp_valid_o high 2 cycles after acceptance, rsp_data_o=0xDEADBEEF, rsp_err_o=0.
REQ-036 SHALL cover: write 0x12345678 to 0x01000010, then read it -> write response data 0, err 0; read returns 0x12345678.
REQ-037 SHALL cover: read 0x00FFFFFC and 0x01001000 (DEPTH_WORDS=1024) -> rsp_err_o=1, rsp_data_o=0; a write to 0x01001000 leaves storage unchanged.
REQ-038 SHALL cover: rsp_ready_i held low 5 cycles in RESP -> outputs stable, req_ready_o=0 throughout; IDLE one cycle after handshake.
REQ-039 SHALL cover: rst asserted in WAIT -> rsp_valid_o=0 immediately, no response after release, next read completes normally.
REQ-040 SHALL cover: read 0x01000002 -> rsp_err_o=1 with IMEM_MISALIGN_CHECK_EN; data of word 0x01000000 without it.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types for the instruction/data memory responder: FSM state encoding
// and the captured response record.
package imem_pkg;

  // Widest data word the response record can carry; DWIDTH must not exceed it.
  localparam int IMEM_DW_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  typedef struct packed {
    logic [IMEM_DW_MAX-1:0] data;
    logic                   err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_array.sv
// Word-addressed storage: synchronous write, combinational read.
// Contents are never reset so they survive a responder reset.
module imem_array #(
  parameter int DWIDTH      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding memory responder with fixed response latency.
// Define IMEM_MISALIGN_CHECK_EN to reject addresses with addr[1:0] != 0.
module imem_responder
  import imem_pkg::*;
#(
  parameter int                DWIDTH      = 32,
  parameter int                AWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASEADDR    = AWIDTH'(32'h01000000),
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output imem_state_e       dbg_state
);

  localparam int              IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AWIDTH:0] LIMIT  = (AWIDTH+1)'(64'(DEPTH_WORDS) * 64'd4);
  localparam logic [3:0]      LAT_M1 = 4'(LATENCY - 1);

  // Handshakes: a transfer happens on a posedge where valid && ready are both
  // high; a valid side holds its payload stable until that edge.

  imem_state_e       state;
  logic [3:0]        cnt;
  imem_rsp_t         pend;
  imem_rsp_t         acc_rsp;
  logic [AWIDTH-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              range_err;
  logic              misalign;
  logic              acc_err;
  logic              accept;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_rdata;
  logic              unused_pend;

  assign off       = req_addr_i - BASEADDR;
  assign idx       = IDX_W'(off >> 2);
  // The offset compare also catches windows that wrap past the top of the address space.
  assign range_err = (req_addr_i < BASEADDR) || ({1'b0, off} >= LIMIT);

`ifdef IMEM_MISALIGN_CHECK_EN
  assign misalign = |req_addr_i[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign acc_err     = range_err || misalign;
  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign mem_we      = accept && req_we_i && !acc_err;
  assign dbg_state   = state;
  assign unused_pend = ^pend.data;

  always_comb begin
    acc_rsp     = '0;
    acc_rsp.err = acc_err;
    if (!acc_err && !req_we_i) acc_rsp.data = IMEM_DW_MAX'(mem_rdata);
  end

  imem_array #(
    .DWIDTH      (DWIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx),
    .wdata (req_wdata_i),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pend        <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pend <= acc_rsp;
            if (LATENCY <= 1) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= acc_rsp.data[DWIDTH-1:0];
              rsp_err_o   <= acc_rsp.err;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (cnt <= 4'd1) begin
            cnt         <= '0;
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= pend.data[DWIDTH-1:0];
            rsp_err_o   <= pend.err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: reset, read/write, range errors,
// response back-pressure, reset mid-flight and misaligned access.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  imem_state_e dbg_state;

  logic [32:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  imem_responder #(
    .DWIDTH      (32),
    .AWIDTH      (32),
    .BASEADDR    (32'h01000000),
    .DEPTH_WORDS (1024),
    .LATENCY     (LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request and returns just after its acceptance edge; then
  // parks junk on the request bus to show idle inputs are ignored.
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic e_err, input logic [31:0] e_data);
    int t;
    exp_q.push_back({e_err, e_data});
    @(negedge clk);
    req_addr = a; req_we = w; req_wdata = d; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'h01000010;
    req_we    = 1'b1;
    req_wdata = 32'hBAD0BAD0;
  endtask

  task automatic wait_rsp(input string tag, input int hold);
    logic [32:0] exp;
    int cyc;
    exp = exp_q.pop_front();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 20);
    check({tag, "_lat"}, 64'(cyc), 64'(LATENCY));
    check({tag, "_data"}, 64'(rsp_data), 64'(exp[31:0]));
    check({tag, "_err"}, 64'(rsp_err), 64'(exp[32]));
    check({tag, "_rdy"}, 64'(req_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(rsp_data), 64'(exp[31:0]));
      check({tag, "_hold_err"}, 64'(rsp_err), 64'(exp[32]));
      check({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 64'(dbg_state), 64'(IDLE));
    check({tag, "_idle_rdy"}, 64'(req_ready), 64'd1);
    check({tag, "_idle_vld"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin : main
    int seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vld", 64'(rsp_valid), 64'd0);
    check("rst_data", 64'(rsp_data), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdy", 64'(req_ready), 64'd1);

    // Preload word 0 then read it back
    send(32'h01000000, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    wait_rsp("wr_w0", 0);
    send(32'h01000000, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
    wait_rsp("rd_w0", 0);

    // Write then read 0x01000010
    send(32'h01000010, 1'b1, 32'h12345678, 1'b0, 32'h0);
    wait_rsp("wr_10", 0);
    send(32'h01000010, 1'b0, 32'h0, 1'b0, 32'h12345678);
    wait_rsp("rd_10", 0);

    // Out-of-range accesses on both sides of the window
    send(32'h00FFFFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    wait_rsp("rd_below", 0);
    send(32'h01001000, 1'b0, 32'h0, 1'b1, 32'h0);
    wait_rsp("rd_above", 0);
    send(32'h01001000, 1'b1, 32'hAAAA5555, 1'b1, 32'h0);
    wait_rsp("wr_above", 0);
    send(32'h01000000, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
    wait_rsp("rd_w0_after_bad_wr", 0);

    // Last valid word
    send(32'h01000FFC, 1'b1, 32'hC0FFEE01, 1'b0, 32'h0);
    wait_rsp("wr_last", 0);
    send(32'h01000FFC, 1'b0, 32'h0, 1'b0, 32'hC0FFEE01);
    wait_rsp("rd_last", 0);

    // Response back-pressure for 5 cycles
    send(32'h01000010, 1'b0, 32'h0, 1'b0, 32'h12345678);
    wait_rsp("hold5", 5);

    // Reset while in WAIT abandons the request
    send(32'h01000010, 1'b0, 32'h0, 1'b0, 32'h12345678);
    @(negedge clk);
    check("mid_state_wait", 64'(dbg_state), 64'(WAIT));
    rst = 1'b0;
    #1;
    check("mid_rst_vld", 64'(rsp_valid), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", 64'(seen), 64'd0);
    send(32'h01000000, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
    wait_rsp("rd_after_rst", 0);

    // Misaligned read
`ifdef IMEM_MISALIGN_CHECK_EN
    send(32'h01000002, 1'b0, 32'h0, 1'b1, 32'h0);
`else
    send(32'h01000002, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
`endif
    wait_rsp("rd_misalign", 0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
